// File: rtl/snapshot_sequencer.sv
// Snapshot sequencer: records periodic sensor frames into a small buffer
// and replays them to the processor over a valid/ack handshake.
module snapshot_sequencer #(
  parameter int DATA_W     = 24,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int SAMPLE_DIV = 500000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        controller,
  input  logic [DATA_W-1:0] sensor_input,
  input  logic              play_ack,
  output logic [DATA_W-1:0] play_data,
  output logic              play_valid,
  output logic              save_signal,
  output logic              load_signal,
  output logic [2:0]        state_load_out,
  output logic [31:0]       load_counter,
  output logic [ADDR_W:0]   frame_count,
  output logic              overrun
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_REC  = 3'b001,
    S_PLAY = 3'b010,
    S_HOLD = 3'b011
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          sync1_q, sync2_q, sync3_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [ADDR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W:0]     fc_q, fc_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                we, enter, tick;
  logic [2:0]          cmd;
  logic                do_stop, do_rec, do_play;

  assign cmd     = sync2_q & ~sync3_q;
  assign do_stop = cmd[2];
  assign do_rec  = cmd[0] & ~cmd[2];
  assign do_play = cmd[1] & ~cmd[2] & ~cmd[0];
  assign tick    = (div_q == DIV_MAX);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    fc_d    = fc_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    we      = 1'b0;
    enter   = 1'b0;
    div_d   = (state_q == S_IDLE || tick) ? '0 : div_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (do_rec) begin
          state_d = S_REC;
          wr_d    = '0;
          fc_d    = '0;
          enter   = 1'b1;
        end else if (do_play && fc_q != '0) begin
          state_d = S_PLAY;
          rd_d    = '0;
          ovr_d   = 1'b0;
          enter   = 1'b1;
        end
      end
      S_REC: begin
        if (do_stop) begin
          state_d = S_IDLE;
          enter   = 1'b1;
        end else if (do_rec) begin
          wr_d  = '0;
          fc_d  = '0;
          enter = 1'b1;
        end else if (tick) begin
          we   = 1'b1;
          wr_d = wr_q + 1'b1;
          fc_d = fc_q + 1'b1;
          // buffer full: stop recording rather than wrap
          if (fc_d == FULL) begin
            state_d = S_IDLE;
            enter   = 1'b1;
          end
        end
      end
      S_PLAY, S_HOLD: begin
        if (do_stop) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          enter   = 1'b1;
        end else if (do_rec) begin
          state_d = S_REC;
          wr_d    = '0;
          fc_d    = '0;
          valid_d = 1'b0;
          enter   = 1'b1;
        end else if (do_play) begin
          state_d = S_PLAY;
          rd_d    = '0;
          ovr_d   = 1'b0;
          valid_d = 1'b0;
          enter   = 1'b1;
        end else if (state_q == S_PLAY) begin
          if (tick) begin
            data_d  = mem_q[rd_q];
            valid_d = 1'b1;
            state_d = S_HOLD;
            enter   = 1'b1;
          end
        end else if (play_ack) begin
          valid_d = 1'b0;
          enter   = 1'b1;
          if ({1'b0, rd_q} == fc_q - 1'b1) begin
            state_d = S_IDLE;
            rd_d    = '0;
          end else begin
            state_d = S_PLAY;
            rd_d    = rd_q + 1'b1;
          end
        end else if (tick) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        enter   = 1'b1;
      end
    endcase
    if (enter) div_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      div_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      fc_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= controller;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      div_q   <= div_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fc_q    <= fc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (we) mem_q[wr_q] <= sensor_input;
  end

  assign play_data      = data_q;
  assign play_valid     = valid_q;
  assign save_signal    = (state_q == S_REC);
  assign load_signal    = (state_q == S_PLAY) || (state_q == S_HOLD);
  assign state_load_out = state_q;
  assign load_counter   = {{(32 - ADDR_W){1'b0}}, rd_q};
  assign frame_count    = fc_q;
  assign overrun        = ovr_q;

endmodule

// File: doc/snapshot_sequencer.md
Name: snapshot_sequencer

Overview:
- Sequences capture and replay of sensor frames between the sensor pins, the VGA overlay and the processor.
- The 3-bit front-panel controller selects record, play or stop.
- In record mode, periodic sensor_input samples go into an internal DEPTH-entry buffer, and save_signal is asserted.
- In play mode, stored frames are replayed one at a time to the processor over a valid/ack handshake, and load_signal plus the replay index are driven for the VGA overlay.

Parameters:
- DATA_W, 24, sensor frame width (lsb 24 bits of sensor_input).
- DEPTH, 16, buffer entries; must be a power of two.
- ADDR_W, 4, log2(DEPTH).
- SAMPLE_DIV, 500000, clock cycles between sample/replay ticks; must be >= 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- controller  in  3  bit0 record, bit1 play, bit2 stop; level inputs, asynchronous to clock.
- sensor_input  in  DATA_W  live sensor frame.
- play_ack  in  1  processor has consumed play_data.
- play_data  out  DATA_W  replayed frame.
- play_valid  out  1  play_data is valid.
- save_signal  out  1  high while in RECORD.
- load_signal  out  1  high while in PLAY or HOLD.
- state_load_out  out  3  IDLE=000, RECORD=001, PLAY=010, HOLD=011.
- load_counter  out  32  replay index rd_ptr, zero-extended.
- frame_count  out  ADDR_W+1  number of valid entries, 0..DEPTH.
- overrun  out  1  sticky flag: a tick arrived in HOLD.

Behaviour:
- Reset values (synchronous, takes effect at the clock edge while reset=1, overrides everything):
  - state=IDLE; all outputs 0.
  - rd_ptr, wr_ptr, frame_count, divider, sync and edge registers all 0.
  - Buffer contents undefined.
- Controller input path:
  - Two-flop synchroniser, then edge detect: cmd[i] = sync2[i] & ~sync3[i].
  - A command acts at the edge after it is detected: state_load_out changes 3 edges after controller rises.
  - Simultaneous commands: stop > record > play.
- Divider:
  - Cleared on every state entry.
  - Counts 0..SAMPLE_DIV-1 in RECORD, PLAY and HOLD; held at 0 in IDLE.
  - tick = (div==SAMPLE_DIV-1); the divider wraps to 0 on the same edge.
- IDLE:
  - record -> RECORD, with wr_ptr=0 and frame_count=0. The old recording is discarded.
  - play with frame_count>0 -> PLAY, with rd_ptr=0. play with frame_count==0 is ignored.
  - stop is a no-op.
- RECORD:
  - On tick: mem[wr_ptr] <= sensor_input[DATA_W-1:0]; wr_ptr++; frame_count++.
  - If the write makes frame_count==DEPTH, go to IDLE on the same edge (buffer full; no wrap, no overwrite).
  - stop -> IDLE; frame_count is kept.
  - record restarts the recording (pointers cleared).
  - play is ignored.
- PLAY:
  - On tick: play_data <= mem[rd_ptr]; play_valid <= 1; -> HOLD.
  - stop -> IDLE. record -> RECORD (restart). play restarts with rd_ptr=0.
- HOLD:
  - play_valid and play_data are held stable until the ack is taken.
  - On play_ack=1: play_valid <= 0. If rd_ptr==frame_count-1, -> IDLE with rd_ptr=0. Otherwise rd_ptr++ and -> PLAY.
  - A tick in HOLD without ack sets overrun=1 (sticky until reset or the next play command) and is otherwise dropped.
  - stop or record while in HOLD: play_valid <= 0 on that edge, then follow the PLAY rules for stop/record.
  - An ack on the same cycle as stop: stop wins, rd_ptr unchanged.
- play_ack while play_valid=0 is ignored.
- Command priority over ticks: on any edge where a command is acted on, the tick on that edge is discarded.
- Buffer read is registered: play_data appears one edge after the tick.
- Outputs are combinational decodes of registered state: save_signal, load_signal, state_load_out.
- load_counter = {zeros, rd_ptr}.
- Widths: frame_count is ADDR_W+1 bits so it can hold DEPTH; pointers are ADDR_W bits.

Test Plan (SAMPLE_DIV=4, DEPTH=4):
- Reset check: assert reset with state=RECORD and frame_count=2 -> next edge: state_load_out=000, frame_count=0, save_signal=0, play_valid=0.
- Record 2 frames: pulse record; after 4 cycles sensor=24'hA1, after 4 more sensor=24'hB2; then stop -> frame_count=2, state_load_out=000.
- Replay with ack: pulse play; ack each valid 2 cycles after it rises -> play_data sequence A1 then B2; load_counter 0 then 1; state_load_out returns to 000 after the second ack; overrun=0.
- Full buffer: record with no stop -> after 4 ticks frame_count=4, state goes to IDLE on the 4th write edge, save_signal drops.
- Overrun and stall: during replay, withhold ack for 6 cycles -> play_valid stays 1, play_data stays stable, overrun=1. A later ack advances rd_ptr.
- Priority and edge cases:
  - controller=3'b111 rising in IDLE -> no state change (stop wins).
  - play with frame_count=0 -> stays IDLE.
  - stop and play_ack together in HOLD -> IDLE, rd_ptr unchanged, play_valid=0.
